// File: rtl/periph_slave_pkg.sv
// Shared types and helpers for the peripheral slave register file.
// Holds the FSM encoding, response opcodes, request direction codes and byte merge.
package periph_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OPC_OK    = 1'b0;
  localparam logic OPC_ERR   = 1'b1;
  localparam logic WEN_READ  = 1'b1;
  localparam logic WEN_WRITE = 1'b0;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/periph_slave_addr_dec.sv
// Address decoder: flags addresses inside the register window and yields the word index.
// Byte offset bits [1:0] never influence the result.
module periph_slave_addr_dec #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          NUM_REGS  = 16,
  parameter int          IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [31:0]      add_i,
  output logic             hit,
  output logic [IDX_W-1:0] index
);

  localparam logic [32:0] SPAN = 33'(4 * NUM_REGS);

  logic [31:0] offset;

  // Compare in 33 bits so a window touching the top of the address space cannot wrap.
  always_comb begin
    offset = add_i - BASE_ADDR;
    hit    = (add_i >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    index  = IDX_W'(offset >> 2);
  end

endmodule

// File: rtl/periph_slave_regfile.sv
// Target-side responder: NUM_REGS byte-writable registers with ID-tagged, fixed-latency responses.
// Handshake: a request is accepted in any cycle where req_i and gnt_o are both high; its response follows as a one-cycle r_valid_o pulse with no backpressure.
module periph_slave_regfile
  import periph_slave_pkg::*;
#(
  parameter int          ID_WIDTH    = 9,
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_i,
  input  logic [31:0]              add_i,
  input  logic                     wen_i,
  input  logic [31:0]              wdata_i,
  input  logic [3:0]               be_i,
  input  logic [ID_WIDTH-1:0]      id_i,
  output logic                     gnt_o,
  output logic                     r_valid_o,
  output logic                     r_opc_o,
  output logic [ID_WIDTH-1:0]      r_id_o,
  output logic [31:0]              r_rdata_o,
  output logic [32*NUM_REGS-1:0]   regs_o
);

  localparam int         IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_e           state, state_next;
  logic [3:0]       cnt, cnt_next;
  logic             accept;
  logic             hit;
  logic [IDX_W-1:0] index;
  logic [31:0]      rd_sel;
  logic [31:0]      regs [NUM_REGS];

  periph_slave_addr_dec #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W)
  ) u_addr_dec (
    .add_i (add_i),
    .hit   (hit),
    .index (index)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      r_valid_o <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      r_valid_o <= (state_next == RESP);
    end
  end

  // RESP behaves like IDLE for acceptance, which gives back-to-back throughput.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE, RESP: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LD;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) state_next = RESP;
        else             cnt_next   = cnt - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt_o  = req_i & rst_ni & ((state == IDLE) | (state == RESP));
    accept = gnt_o;
    rd_sel = hit ? regs[index] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else if (accept && hit && (wen_i == WEN_WRITE)) begin
      regs[index] <= be_merge(regs[index], wdata_i, be_i);
    end
  end

  // Response fields are latched at acceptance and held until the next one.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_id_o    <= '0;
      r_opc_o   <= OPC_OK;
      r_rdata_o <= '0;
    end else if (accept) begin
      r_id_o    <= id_i;
      r_opc_o   <= hit ? OPC_OK : OPC_ERR;
      r_rdata_o <= (wen_i == WEN_READ) ? rd_sel : '0;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_o[32*k +: 32] = regs[k];
  end

endmodule

// File: tb/tb_periph_slave_regfile.sv
// Directed and scoreboarded checks of periph_slave_regfile at WAIT_CYCLES 0, 3 and 2.
// All three instances share the request inputs; sel picks whose outputs are examined.
module tb_periph_slave_regfile;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          IDW  = 9;
  localparam int          NR   = 16;

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            req;
  logic [31:0]     add;
  logic            wen;
  logic [31:0]     wdata;
  logic [3:0]      be;
  logic [IDW-1:0]  id;

  logic            gnt_a   [3];
  logic            rv_a    [3];
  logic            opc_a   [3];
  logic [IDW-1:0]  rid_a   [3];
  logic [31:0]     rdata_a [3];
  logic [32*NR-1:0] regs_a [3];

  periph_slave_regfile #(.ID_WIDTH(IDW), .NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_w0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
    .be_i(be), .id_i(id), .gnt_o(gnt_a[0]), .r_valid_o(rv_a[0]), .r_opc_o(opc_a[0]),
    .r_id_o(rid_a[0]), .r_rdata_o(rdata_a[0]), .regs_o(regs_a[0]));

  periph_slave_regfile #(.ID_WIDTH(IDW), .NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_w3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
    .be_i(be), .id_i(id), .gnt_o(gnt_a[1]), .r_valid_o(rv_a[1]), .r_opc_o(opc_a[1]),
    .r_id_o(rid_a[1]), .r_rdata_o(rdata_a[1]), .regs_o(regs_a[1]));

  periph_slave_regfile #(.ID_WIDTH(IDW), .NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) u_w2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
    .be_i(be), .id_i(id), .gnt_o(gnt_a[2]), .r_valid_o(rv_a[2]), .r_opc_o(opc_a[2]),
    .r_id_o(rid_a[2]), .r_rdata_o(rdata_a[2]), .regs_o(regs_a[2]));

  int sel   = 0;
  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  // scoreboard state: {id, opc, rdata} plus the cycle each response is due
  logic [IDW+32:0] exp_q [$];
  int              due_q [$];
  logic [31:0]     mem   [NR];

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] b, input logic [IDW-1:0] i);
    req = r; add = a; wen = w; wdata = d; be = b; id = i;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, '0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [32*NR-1:0] model_regs();
    logic [32*NR-1:0] v;
    for (int k = 0; k < NR; k++) v[32*k +: 32] = mem[k];
    return v;
  endfunction

  task automatic check_resp(input int w);
    logic [IDW+32:0] e;
    int              d;
    if (rv_a[sel]) begin
      if (exp_q.size() == 0) begin
        chk($sformatf("rnd_w%0d_spurious", w), 512'(rv_a[sel]), 512'(0));
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        chk($sformatf("rnd_w%0d_resp", w), 512'({rid_a[sel], opc_a[sel], rdata_a[sel]}), 512'(e));
        chk($sformatf("rnd_w%0d_latency", w), 512'(cyc), 512'(d));
      end
    end
  endtask

  task automatic run_random(input int s, input int w, input int n);
    logic [31:0] a, off, rd;
    logic        h;
    sel = s;
    do_reset();
    for (int k = 0; k < NR; k++) mem[k] = '0;
    exp_q.delete();
    due_q.delete();
    cyc = 0;
    for (int k = 0; k < n + 12; k++) begin
      step();
      check_resp(w);
      if (k < n) begin
        if ($urandom_range(0, 5) == 0) begin
          case ($urandom_range(0, 2))
            0:       a = BASE + 32'd64 + 32'($urandom_range(0, 31));
            1:       a = BASE - 32'd1 - 32'($urandom_range(0, 31));
            default: a = 32'h8000_0000 | $urandom;
          endcase
        end else begin
          a = BASE + 32'(4 * $urandom_range(0, NR - 1)) + 32'($urandom_range(0, 3));
        end
        drive(($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 1)), $urandom,
              4'($urandom_range(0, 15)), IDW'(k));
      end else begin
        req = 1'b0;
      end
      settle();
      if (req && gnt_a[sel]) begin
        off = add - BASE;
        h   = (add >= BASE) && (off < 32'(4 * NR));
        rd  = (h && wen) ? mem[off[5:2]] : 32'h0;
        exp_q.push_back({id, ~h, rd});
        due_q.push_back(cyc + 1 + w);
        if (h && !wen) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) mem[off[5:2]][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
    chk($sformatf("rnd_w%0d_drain", w), 512'(exp_q.size()), 512'(0));
    chk($sformatf("rnd_w%0d_regs", w), 512'(regs_a[sel]), 512'(model_regs()));
  endtask

  logic [32*NR-1:0] ev;

  initial begin
    // ---- WAIT_CYCLES = 0: reset values ----
    sel   = 0;
    rst_n = 1'b0;
    drive(1'b1, BASE + 32'h8, 1'b0, 32'hDEAD_BEEF, 4'hF, 9'd5);
    settle();
    chk("rst_gnt_low", 512'(gnt_a[0]), 512'(0));
    step();
    chk("rst_rvalid", 512'(rv_a[0]), 512'(0));
    chk("rst_rid",    512'(rid_a[0]), 512'(0));
    chk("rst_opc",    512'(opc_a[0]), 512'(0));
    chk("rst_rdata",  512'(rdata_a[0]), 512'(0));
    chk("rst_regs",   512'(regs_a[0]), 512'(0));
    step();
    rst_n = 1'b1;

    // ---- full write then read-after-write ----
    settle();
    chk("wr_gnt", 512'(gnt_a[0]), 512'(1));
    step();
    drive(1'b1, BASE + 32'h8, 1'b1, 32'h0, 4'hF, 9'd6);
    settle();
    chk("rd_gnt",       512'(gnt_a[0]), 512'(1));
    chk("wr_rvalid",    512'(rv_a[0]), 512'(1));
    chk("wr_rid",       512'(rid_a[0]), 512'(5));
    chk("wr_opc",       512'(opc_a[0]), 512'(0));
    chk("wr_rdata",     512'(rdata_a[0]), 512'(0));
    chk("wr_reg2",      512'(regs_a[0][95:64]), 512'(32'hDEAD_BEEF));
    step();
    req = 1'b0;
    settle();
    chk("rd_rvalid", 512'(rv_a[0]), 512'(1));
    chk("rd_rid",    512'(rid_a[0]), 512'(6));
    chk("rd_rdata",  512'(rdata_a[0]), 512'(32'hDEAD_BEEF));
    step();
    chk("idle_rvalid", 512'(rv_a[0]), 512'(0));
    chk("hold_rid",    512'(rid_a[0]), 512'(6));
    chk("hold_rdata",  512'(rdata_a[0]), 512'(32'hDEAD_BEEF));

    // ---- partial write, read with low address bits set ----
    drive(1'b1, BASE + 32'h8, 1'b0, 32'h1122_3344, 4'h5, 9'd7);
    step();
    drive(1'b1, BASE + 32'hA, 1'b1, 32'h0, 4'hF, 9'd8);
    settle();
    chk("pw_rid", 512'(rid_a[0]), 512'(7));
    step();
    drive(1'b1, BASE + 32'h8, 1'b0, 32'hFFFF_FFFF, 4'h0, 9'd11);
    settle();
    chk("pw_rdata", 512'(rdata_a[0]), 512'(32'hDE22_BE44));
    chk("pw_opc",   512'(opc_a[0]), 512'(0));

    // ---- be=0 write, misses on both sides of the window, top register ----
    step();
    drive(1'b1, BASE + 32'h40, 1'b1, 32'h0, 4'hF, 9'd12);
    settle();
    chk("be0_rid", 512'(rid_a[0]), 512'(11));
    chk("be0_opc", 512'(opc_a[0]), 512'(0));
    step();
    drive(1'b1, BASE - 32'h4, 1'b1, 32'h0, 4'hF, 9'd13);
    settle();
    chk("miss_hi_rid",   512'(rid_a[0]), 512'(12));
    chk("miss_hi_opc",   512'(opc_a[0]), 512'(1));
    chk("miss_hi_rdata", 512'(rdata_a[0]), 512'(0));
    step();
    drive(1'b1, BASE + 32'h40, 1'b0, 32'hFFFF_FFFF, 4'hF, 9'd14);
    settle();
    chk("miss_lo_rid", 512'(rid_a[0]), 512'(13));
    chk("miss_lo_opc", 512'(opc_a[0]), 512'(1));
    step();
    drive(1'b1, BASE + 32'h3C, 1'b1, 32'h0, 4'hF, 9'd15);
    settle();
    chk("miss_wr_opc", 512'(opc_a[0]), 512'(1));
    step();
    req = 1'b0;
    settle();
    chk("top_opc",   512'(opc_a[0]), 512'(0));
    chk("top_rid",   512'(rid_a[0]), 512'(15));
    chk("top_rdata", 512'(rdata_a[0]), 512'(0));
    ev = '0;
    ev[95:64] = 32'hDE22_BE44;
    chk("regs_after_miss", 512'(regs_a[0]), 512'(ev));

    // ---- WAIT_CYCLES = 3: held requests ----
    sel = 1;
    do_reset();
    drive(1'b1, BASE + 32'h4, 1'b0, 32'hCAFE_F00D, 4'hF, 9'd1);
    settle();
    chk("w3_gnt_c0", 512'(gnt_a[1]), 512'(1));
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("w3_gnt_c%0d", c), 512'(gnt_a[1]), 512'(0));
      chk($sformatf("w3_rv_c%0d", c),  512'(rv_a[1]), 512'(0));
    end
    step();
    drive(1'b1, BASE + 32'h4, 1'b1, 32'h0, 4'hF, 9'd2);
    settle();
    chk("w3_rv_c4",  512'(rv_a[1]), 512'(1));
    chk("w3_rid_c4", 512'(rid_a[1]), 512'(1));
    chk("w3_gnt_c4", 512'(gnt_a[1]), 512'(1));
    for (int c = 5; c <= 7; c++) begin
      step();
      chk($sformatf("w3_gnt_c%0d", c), 512'(gnt_a[1]), 512'(0));
      chk($sformatf("w3_rv_c%0d", c),  512'(rv_a[1]), 512'(0));
    end
    step();
    req = 1'b0;
    settle();
    chk("w3_rv_c8",    512'(rv_a[1]), 512'(1));
    chk("w3_rid_c8",   512'(rid_a[1]), 512'(2));
    chk("w3_rdata_c8", 512'(rdata_a[1]), 512'(32'hCAFE_F00D));

    // ---- reset while a read is waiting ----
    step();
    drive(1'b1, BASE + 32'h4, 1'b1, 32'h0, 4'hF, 9'd3);
    settle();
    chk("w3_rst_acc_gnt", 512'(gnt_a[1]), 512'(1));
    step();
    req   = 1'b0;
    rst_n = 1'b0;
    step();
    chk("w3_rst_rv",    512'(rv_a[1]), 512'(0));
    chk("w3_rst_rid",   512'(rid_a[1]), 512'(0));
    chk("w3_rst_rdata", 512'(rdata_a[1]), 512'(0));
    chk("w3_rst_regs",  512'(regs_a[1]), 512'(0));
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("w3_no_rv_%0d", c), 512'(rv_a[1]), 512'(0));
    end
    drive(1'b1, BASE, 1'b1, 32'h0, 4'hF, 9'd4);
    settle();
    chk("w3_post_rst_gnt", 512'(gnt_a[1]), 512'(1));
    step();
    req = 1'b0;

    // ---- scoreboarded random traffic ----
    run_random(0, 0, 300);
    run_random(2, 2, 300);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
